// File: rtl/fc1_frame_sched_if.sv
// Handshake bundle between the layer-2 stream, the FC1 scheduler and FC1 itself.
// master = stream/FC1 side, slave = scheduler side.
interface fc1_frame_sched_if;
  logic up_valid;
  logic up_ready;
  logic fc1_valid_in;
  logic fc1_out_valid;

  modport master (
    output up_valid,
    output fc1_out_valid,
    input  up_ready,
    input  fc1_valid_in
  );

  modport slave (
    input  up_valid,
    input  fc1_out_valid,
    output up_ready,
    output fc1_valid_in
  );
endinterface

// File: rtl/fc1_frame_sched.sv
// Frame scheduler for FC1: gates input beats into FC1, counts its output beats,
// and supervises it with a watchdog and sticky protocol-error flags.
module fc1_frame_sched #(
  parameter int IN_BEATS  = 16,
  parameter int OUT_BEATS = 32,
  parameter int TIMEOUT   = 20000,
  parameter int TO_W      = 15,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fc1_frame_sched_if.slave     bus,
  input  logic                 enable,
  input  logic                 weights_ready,
  input  logic                 err_clr,
  output logic                 busy,
  output logic                 frame_done,
  output logic [CNT_W-1:0]     frame_cnt,
  output logic                 err_timeout,
  output logic                 err_proto
);
  localparam int IN_W  = $clog2(IN_BEATS + 1);
  localparam int OUT_W = $clog2(OUT_BEATS + 1);

  typedef enum logic [2:0] {IDLE, FEED, WAIT_OUT, DONE, ERR} state_t;

  state_t             state_q, state_d;
  logic               busy_q, busy_d;
  logic               frame_done_q, frame_done_d;
  logic               err_timeout_q, err_timeout_d;
  logic               err_proto_q, err_proto_d;
  logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic [IN_W-1:0]    in_cnt_q, in_cnt_d;
  logic [OUT_W-1:0]   out_cnt_q, out_cnt_d;
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;

  // Zero-latency pass-through: FC1 only sees beats while we are loading it.
  assign bus.up_ready     = (state_q == FEED);
  assign bus.fc1_valid_in = bus.up_valid & bus.up_ready;

  always_comb begin
    state_d       = state_q;
    busy_d        = busy_q;
    frame_done_d  = 1'b0;
    err_timeout_d = err_timeout_q;
    err_proto_d   = err_proto_q;
    frame_cnt_d   = frame_cnt_q;
    in_cnt_d      = in_cnt_q;
    out_cnt_d     = out_cnt_q;
    to_cnt_d      = to_cnt_q;

    case (state_q)
      IDLE: begin
        if (bus.fc1_out_valid) begin
          state_d     = ERR;
          err_proto_d = 1'b1;
          busy_d      = 1'b1;
        end else if (enable && weights_ready) begin
          state_d  = FEED;
          busy_d   = 1'b1;
          in_cnt_d = '0;
        end
      end
      FEED: begin
        if (bus.fc1_out_valid) begin
          state_d     = ERR;
          err_proto_d = 1'b1;
        end else if (bus.up_valid) begin
          in_cnt_d = in_cnt_q + IN_W'(1);
          if (in_cnt_q == IN_W'(IN_BEATS - 1)) begin
            state_d   = WAIT_OUT;
            out_cnt_d = '0;
            to_cnt_d  = '0;
          end
        end
      end
      WAIT_OUT: begin
        to_cnt_d = to_cnt_q + TO_W'(1);
        if (bus.fc1_out_valid) begin
          out_cnt_d = out_cnt_q + OUT_W'(1);
        end
        // The final output beat beats the watchdog when both land together.
        if (bus.fc1_out_valid && (out_cnt_q == OUT_W'(OUT_BEATS - 1))) begin
          state_d      = DONE;
          frame_done_d = 1'b1;
          frame_cnt_d  = frame_cnt_q + CNT_W'(1);
        end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
          state_d       = ERR;
          err_timeout_d = 1'b1;
        end
      end
      DONE: begin
        if (bus.fc1_out_valid) begin
          state_d     = ERR;
          err_proto_d = 1'b1;
        end else begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      ERR: begin
        if (err_clr) begin
          state_d       = IDLE;
          busy_d        = 1'b0;
          err_timeout_d = 1'b0;
          err_proto_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      err_timeout_q <= 1'b0;
      err_proto_q   <= 1'b0;
      frame_cnt_q   <= '0;
      in_cnt_q      <= '0;
      out_cnt_q     <= '0;
      to_cnt_q      <= '0;
    end else begin
      state_q       <= state_d;
      busy_q        <= busy_d;
      frame_done_q  <= frame_done_d;
      err_timeout_q <= err_timeout_d;
      err_proto_q   <= err_proto_d;
      frame_cnt_q   <= frame_cnt_d;
      in_cnt_q      <= in_cnt_d;
      out_cnt_q     <= out_cnt_d;
      to_cnt_q      <= to_cnt_d;
    end
  end

  assign busy        = busy_q;
  assign frame_done  = frame_done_q;
  assign frame_cnt   = frame_cnt_q;
  assign err_timeout = err_timeout_q;
  assign err_proto   = err_proto_q;
endmodule

// File: tb/tb_fc1_frame_sched.sv
// Bench for fc1_frame_sched: directed frame scenarios plus a random soak, all
// compared every cycle against a phase-level model of the scheduler.
module tb_fc1_frame_sched;
  localparam int IN_BEATS  = 16;
  localparam int OUT_BEATS = 32;
  localparam int TIMEOUT   = 100;

  logic        clk = 1'b0;
  logic        rst_n, enable, weights_ready, err_clr;
  logic        busy, frame_done, err_timeout, err_proto;
  logic [15:0] frame_cnt;

  always #5 clk = ~clk;

  fc1_frame_sched_if bus_if();

  fc1_frame_sched #(
    .IN_BEATS(IN_BEATS), .OUT_BEATS(OUT_BEATS), .TIMEOUT(TIMEOUT), .TO_W(7), .CNT_W(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus_if), .enable(enable),
    .weights_ready(weights_ready), .err_clr(err_clr), .busy(busy),
    .frame_done(frame_done), .frame_cnt(frame_cnt),
    .err_timeout(err_timeout), .err_proto(err_proto)
  );

  int total = 0;
  int bad   = 0;

  // stimulus values for the current cycle
  bit rn = 1'b0, en = 1'b0, wr = 1'b0, ec = 1'b0, uv = 1'b0, ov = 1'b0;

  // model: which phase of a frame we are in, plus plain counters
  bit          m_feed = 0, m_wait = 0, m_done = 0, m_err = 0, m_eto = 0, m_epr = 0;
  int          m_beats = 0, m_strobes = 0, m_age = 0;
  logic [15:0] m_frames = '0;

  // observations of the DUT for the hand-computed checks
  int cyc = 0, vin_cnt = 0, done_cnt = 0;
  int last_done_cyc = -1, last_rise_cyc = -1, last_vin_cyc = -1, last_ov_cyc = -1, eto_cyc = -1;
  bit prev_ready = 0, prev_eto = 0, chk_en = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_step();
    if (!rn) begin
      m_feed = 0; m_wait = 0; m_done = 0; m_err = 0; m_eto = 0; m_epr = 0;
      m_beats = 0; m_strobes = 0; m_age = 0; m_frames = '0;
    end else if (m_err) begin
      if (ec) begin m_err = 0; m_eto = 0; m_epr = 0; end
    end else if (m_feed) begin
      if (ov) begin
        m_feed = 0; m_err = 1; m_epr = 1;
      end else if (uv) begin
        m_beats++;
        if (m_beats == IN_BEATS) begin m_feed = 0; m_wait = 1; m_strobes = 0; m_age = 0; end
      end
    end else if (m_wait) begin
      m_age++;
      if (ov) m_strobes++;
      if (ov && m_strobes == OUT_BEATS) begin
        m_wait = 0; m_done = 1; m_frames++;
      end else if (m_age == TIMEOUT) begin
        m_wait = 0; m_err = 1; m_eto = 1;
      end
    end else if (m_done) begin
      m_done = 0;
      if (ov) begin m_err = 1; m_epr = 1; end
    end else begin
      if (ov) begin m_err = 1; m_epr = 1; end
      else if (en && wr) begin m_feed = 1; m_beats = 0; end
    end
  endtask

  // One clock: drive at negedge, compare mid-cycle, advance the model at posedge.
  task automatic step();
    @(negedge clk);
    rst_n = rn; enable = en; weights_ready = wr; err_clr = ec;
    bus_if.up_valid = uv; bus_if.fc1_out_valid = ov;
    #1;
    if (chk_en) begin
      chk("up_ready",     {31'd0, bus_if.up_ready},     {31'd0, m_feed});
      chk("fc1_valid_in", {31'd0, bus_if.fc1_valid_in}, {31'd0, uv & m_feed});
      chk("busy",         {31'd0, busy},                {31'd0, m_feed | m_wait | m_done | m_err});
      chk("frame_done",   {31'd0, frame_done},          {31'd0, m_done});
      chk("frame_cnt",    {16'd0, frame_cnt},           {16'd0, m_frames});
      chk("err_timeout",  {31'd0, err_timeout},         {31'd0, m_eto});
      chk("err_proto",    {31'd0, err_proto},           {31'd0, m_epr});
    end
    if (bus_if.fc1_valid_in === 1'b1) begin vin_cnt++; last_vin_cyc = cyc; end
    if (frame_done === 1'b1) begin
      done_cnt++; last_done_cyc = cyc;
      $display("frame_done cyc=%0d frame_cnt=%0d", cyc, frame_cnt);
    end
    if (bus_if.up_ready === 1'b1 && !prev_ready) last_rise_cyc = cyc;
    prev_ready = (bus_if.up_ready === 1'b1);
    if (err_timeout === 1'b1 && !prev_eto) eto_cyc = cyc;
    prev_eto = (err_timeout === 1'b1);
    @(posedge clk);
    model_step();
    chk_en = 1;
    cyc++;
  endtask

  // Push nb beats into FC1; gap_a/gap_b name beat indices preceded by an idle cycle.
  task automatic feed(input int nb, input int gap_a, input int gap_b, input bit rnd);
    int beats = 0;
    int guard = 0;
    bit ga = (gap_a >= 0);
    bit gb = (gap_b >= 0);
    ov = 0;
    while (beats < nb && guard < 400) begin
      uv = 1;
      if (m_feed) begin
        if (ga && beats == gap_a) begin uv = 0; ga = 0; end
        else if (gb && beats == gap_b) begin uv = 0; gb = 0; end
        else if (rnd && $urandom_range(0, 3) == 0) uv = 0;
      end
      if (uv && m_feed) beats++;
      step();
      guard++;
    end
    if (beats < nb) begin
      total++; bad++;
      $display("FAIL feed_budget beats=%0d want=%0d", beats, nb);
    end
  endtask

  task automatic strobes(input int n, input bit hold_uv);
    int s = 0;
    int guard = 0;
    uv = hold_uv;
    while (s < n && guard < 300) begin
      ov = ($urandom_range(0, 7) != 0);
      if (ov) begin s++; last_ov_cyc = cyc; end
      step();
      guard++;
    end
    ov = 0;
    if (s < n) begin
      total++; bad++;
      $display("FAIL strobe_budget strobes=%0d want=%0d", s, n);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog sim time exceeded");
    $fatal(1);
  end

  initial begin
    int v0, d0, d1, lb;
    rst_n = 0; enable = 0; weights_ready = 0; err_clr = 0;
    bus_if.up_valid = 0; bus_if.fc1_out_valid = 0;

    // reset, then enabled but weights not ready: nothing may start
    rn = 0;
    repeat (3) step();
    rn = 1; en = 1; wr = 0; uv = 1;
    repeat (20) step();
    chk("idle_no_ready_rise", last_rise_cyc, -1);
    chk("idle_busy", {31'd0, busy}, 32'd0);

    // normal frame, gaps before beats 3 and 9, a 17th up_valid held during WAIT_OUT
    wr = 1;
    v0 = vin_cnt; d0 = done_cnt;
    feed(IN_BEATS, 2, 8, 0);
    uv = 1;
    step();
    #2;
    chk("ready_low_after_last_beat", {31'd0, bus_if.up_ready}, 32'd0);
    strobes(OUT_BEATS, 1);
    step();
    chk("f1_vin_pulses", vin_cnt - v0, 16);
    chk("f1_done_pulses", done_cnt - d0, 1);
    chk("f1_done_latency", last_done_cyc - last_ov_cyc, 1);
    chk("f1_frame_cnt", {16'd0, frame_cnt}, 32'd1);
    d1 = last_done_cyc;

    // back-to-back second frame
    feed(IN_BEATS, -1, -1, 1);
    chk("b2b_ready_rise", last_rise_cyc - d1, 2);
    strobes(OUT_BEATS, 0);
    step();
    chk("f2_frame_cnt", {16'd0, frame_cnt}, 32'd2);
    chk("f2_done_pulses", done_cnt - d0, 2);

    // watchdog: one strobe short
    d0 = done_cnt;
    feed(IN_BEATS, -1, -1, 1);
    lb = last_vin_cyc;
    strobes(OUT_BEATS - 1, 0);
    for (int g = 0; g < 200 && eto_cyc < lb; g++) step();
    chk("timeout_latency", eto_cyc - lb, TIMEOUT + 1);
    chk("timeout_no_done", done_cnt - d0, 0);
    ec = 1; step(); ec = 0; #2;
    chk("to_clr_flag", {31'd0, err_timeout}, 32'd0);
    chk("to_clr_busy", {31'd0, busy}, 32'd0);
    chk("to_clr_frame_cnt", {16'd0, frame_cnt}, 32'd2);

    // protocol error: FC1 output strobe during beat 5 of FEED
    feed(4, -1, -1, 0);
    uv = 1; ov = 1; step(); ov = 0; #2;
    chk("proto_flag", {31'd0, err_proto}, 32'd1);
    chk("proto_ready", {31'd0, bus_if.up_ready}, 32'd0);
    step(); step();
    ec = 1; step(); ec = 0; #2;
    chk("proto_clr_flag", {31'd0, err_proto}, 32'd0);
    chk("proto_clr_busy", {31'd0, busy}, 32'd0);

    // synchronous reset after 8 beats, then a clean frame
    feed(8, -1, -1, 0);
    rn = 0; uv = 1; step(); rn = 1; #2;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
    chk("rst_ready", {31'd0, bus_if.up_ready}, 32'd0);
    feed(IN_BEATS, -1, -1, 1);
    strobes(OUT_BEATS, 0);
    step();
    chk("post_rst_frame_cnt", {16'd0, frame_cnt}, 32'd1);

    // random soak against the model
    for (int i = 0; i < 1500; i++) begin
      en = ($urandom_range(0, 3) != 0);
      wr = ($urandom_range(0, 2) != 0);
      uv = $urandom_range(0, 1);
      ov = m_wait ? ($urandom_range(0, 4) != 0) : ($urandom_range(0, 49) == 0);
      ec = ($urandom_range(0, 7) == 0);
      rn = ($urandom_range(0, 299) != 0);
      step();
    end
    rn = 1; ov = 0; ec = 0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
